// File: rtl/control_seq.sv
// control_seq -- microcode sequencer for a small 8-bit accumulator CPU.
//
// A registered microstep counter (T0..T4) plus a sticky halt flag. Every
// bus/PC strobe is a purely combinational decode of the current step, the
// instruction register, the flags, run, halted and RST.
//
// Optional build macro: STEP_SKIP_EN
//   defined   -> each instruction returns to T0 right after its last step
//                that asserts any strobe (short instructions finish early).
//   undefined -> every instruction occupies exactly five cycles, T0..T4.
// Per-step strobe patterns are identical in both builds.
//
// Flow control: run is a level-sensitive enable. A step is consumed on a
// rising edge only when run=1, halted=0 and RST=0; in any cycle where that
// is not true the step holds and every strobe is forced to 0, so nothing
// downstream ever sees a strobe for a step that will not complete.

module control_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] instr,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       run,
  output logic       count_en,
  output logic       WEN,
  output logic [3:0] jaddr,
  output logic       pc_out,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halted,
  output logic [2:0] step
);

  // Microstep encoding; the numeric value is what appears on the step port.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  step_e      step_q, step_d;
  logic       halted_q, halted_d;

  logic [3:0] opcode;
  logic       active;
  logic       jump_taken;
  step_e      last_step;

  assign opcode = instr[7:4];

  // A step executes only when running, not halted and not in reset.
  assign active = run & ~halted_q & ~RST;

  // The PC load value is always the operand; it only matters while WEN=1.
  assign jaddr  = instr[3:0];
  assign step   = step_q;
  assign halted = halted_q;

  // Decide whether the current opcode's jump condition holds this cycle.
  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = flag_c;
      OP_JZ:   jump_taken = flag_z;
      default: jump_taken = 1'b0;
    endcase
  end

  // Final microstep of the current instruction before wrapping to T0.
  always_comb begin
    last_step = T4;
`ifdef STEP_SKIP_EN
    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
`else
    last_step = T4;
`endif
  end

  // Next-state logic for the step counter and the sticky halt flag.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (RST) begin
      step_d   = T0;
      halted_d = 1'b0;
    end else if (active) begin
      if ((step_q == T2) && (opcode == OP_HLT)) begin
        // Halt parks the sequencer at T0 until the next reset.
        halted_d = 1'b1;
        step_d   = T0;
      end else if (step_q == last_step) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Strobe decode: fetch in T0/T1, opcode-specific execute in T2..T4.
  always_comb begin
    count_en = 1'b0;
    WEN      = 1'b0;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    ram_in   = 1'b0;
    ram_out  = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    flags_in = 1'b0;
    out_in   = 1'b0;
    if (active) begin
      case (step_q)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out  = 1'b1;
          ir_in    = 1'b1;
          count_en = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP, OP_JC, OP_JZ: begin
              // An untaken conditional jump is a silent step.
              ir_out = jump_taken;
              WEN    = jump_taken;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            default: begin
              // NOP, HLT and undefined opcodes assert nothing here.
            end
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: begin
            end
          endcase
        end
        T4: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            flags_in = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 The block SHALL have one clock and reset, which is synchronous and active-high: CLK input 1 clock, rising edge; RST input 1 synchronous active-high reset.
REQ-002 instr input 8: instruction register contents; [7:4] opcode, [3:0] operand.
REQ-003 flag_c, flag_z input 1 each: carry/zero flags from the flags register.
REQ-004 run input 1: 1 advances sequencer; 0 freezes step and forces all strobes to 0.
REQ-005 count_en output 1: PC increment strobe; WEN output 1: PC load strobe; jaddr output 4: PC load value.
REQ-006 pc_out, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in: outputs, 1 bit each, bus control strobes.
REQ-007 halted output 1: sticky halt status; step output 3: current microstep T0..T4.

Function
REQ-008 step SHALL be a registered 0..4 counter; all strobes SHALL be combinational decodes of step, instr, flags, run, halted.
REQ-009 T0: pc_out, mar_in. T1: ram_out, ir_in, count_en. T0/T1 are identical for all opcodes.
REQ-010 LDA 0001: T2 ir_out,mar_in; T3 ram_out,a_in.
REQ-011 ADD 0010: T2 ir_out,mar_in; T3 ram_out,b_in; T4 alu_out,a_in,flags_in. SUB 0011: same plus alu_sub in T4.
REQ-012 STA 0100: T2 ir_out,mar_in; T3 a_out,ram_in. LDI 0101: T2 ir_out,a_in.
REQ-013 JMP 0110: T2 ir_out,WEN. JC 0111: as JMP only if flag_c=1. JZ 1000: as JMP only if flag_z=1; flags sampled in T2 cycle.
REQ-014 jaddr SHALL equal instr[3:0] at all times; meaningful only when WEN=1.
REQ-015 OUT 1110: T2 a_out,out_in. HLT 1111: T2 sets halted on the next edge; no other strobe.
REQ-016 NOP 0000 and undefined opcodes 1001-1101: no strobes in T2-T4.
REQ-017 count_en and WEN SHALL never be asserted in the same cycle.
REQ-018 At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) SHALL be asserted per cycle.
REQ-019 Step advance: on each edge with run=1, halted=0, RST=0, step goes to step+1, or to 0 from the last step (REQ-026/027).
REQ-020 run=0: step holds; every strobe including count_en/WEN is 0; resumes at held step when run=1.
REQ-021 halted=1: step holds at 0, all strobes 0, run ignored; cleared only by RST.

Reset
REQ-022 RST=1 at an edge: step:=0, halted:=0, regardless of run or current step (including mid-instruction).
REQ-023 While RST=1 all strobes SHALL be 0 combinationally.
REQ-024 First cycle after RST deasserts SHALL be T0 with pc_out=1, mar_in=1.
REQ-025 No output SHALL be X after the first reset edge.

Configuration
REQ-026 Macro STEP_SKIP_EN defined: step returns to 0 after the last step with any strobe for the opcode (LDI/OUT/NOP/untaken jump end after T2; LDA/STA after T3; ADD/SUB after T4).
REQ-027 STEP_SKIP_EN undefined: every instruction takes exactly 5 cycles T0-T4; unused steps assert no strobes.
REQ-028 T0/T1 and per-step strobes SHALL be identical in both builds; only instruction cycle count differs.

Verification
REQ-029 Reset, run=1, instr=0x00 -> T0 pc_out,mar_in; T1 count_en,ram_out,ir_in; no strobes T2; next T0 at cycle 3 (skip) or cycle 5 (no skip).
REQ-030 instr=0x2E (ADD 14) -> T2 ir_out,mar_in; T3 ram_out,b_in; T4 alu_out,a_in,flags_in, alu_sub=0; 0x3E same with alu_sub=1 in T4.
REQ-031 instr=0x79, flag_c=0 then 1 -> T2 WEN=0, then WEN=1 with jaddr=9; count_en=0 in that cycle.
REQ-032 instr=0xF0 -> halted=1 after T2 edge; 10 further cycles with run toggling show step=0, all strobes 0; RST clears halted.
REQ-033 run=0 during T1 of LDA for 3 cycles -> count_en=0 all 3 cycles, step=1 held; one count_en pulse after run=1.
REQ-034 RST=1 during T3 of STA -> no ram_in that cycle; next cycle step=0, T0 strobes.
